adder_tree_lane_gather: RTL and testbench

- Upstream feeder for the 8-input, 3-level adder tree.
- Accepts a serial valid/ready stream of ADDER_WIDTH-bit operands and packs them into LANES-wide operand vectors.
- Presents each vector as one parallel word on a valid/ready output that drives the tree's input registers (lane k maps to tree leaf k in isum0_0_0_0 … isum0_1_1_1 order).
- Ping-pong double buffering sustains one operand per cycle.

---
 rtl/adder_tree_lane_gather.sv | 96 +++++++++
 tb/tb_adder_tree_lane_gather.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_lane_gather.sv
// Serial-to-parallel operand gatherer feeding the 8-leaf adder tree.
// Two ping-pong banks let one bank fill while the other waits for the tree.
module adder_tree_lane_gather #(
    parameter int unsigned ADDER_WIDTH = 64,
    parameter int unsigned LANES       = 8,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDER_WIDTH-1:0]       in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ADDER_WIDTH-1:0] out_lanes,
    output logic [CNT_W-1:0]             out_count
);

    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

    logic [ADDER_WIDTH-1:0] data_q [2][LANES];
    logic [CNT_W-1:0]       count_q [2];
    logic [1:0]             full_q, full_d;
    logic [IdxW-1:0]        wr_idx_q, wr_idx_d;
    logic                   wb_q, wb_d;
    logic                   rb_q, rb_d;
    logic                   accept, complete, drain;

    // in_ready looks only at registered state, never at in_valid or out_ready.
    assign in_ready  = rst_n & ~full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign accept    = in_valid & in_ready;
    assign complete  = accept & (in_last | (wr_idx_q == LastIdx));
    assign drain     = out_valid & out_ready;

    always_comb begin
        full_d   = full_q;
        wr_idx_d = wr_idx_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        if (accept) begin
            wr_idx_d = complete ? '0 : wr_idx_q + IdxW'(1);
        end
        if (complete) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        // A completing bank is never the draining bank: wb full blocks input.
        if (drain) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_idx_q   <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            count_q[0] <= '0;
            count_q[1] <= '0;
        end else begin
            full_q   <= full_d;
            wr_idx_q <= wr_idx_d;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            if (complete) begin
                count_q[wb_q] <= CNT_W'(wr_idx_q) + CNT_W'(1);
            end
        end
    end

    // Lane data needs no reset: lanes at or above count are masked on output.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[wb_q][wr_idx_q] <= in_data;
        end
    end

    always_comb begin
        out_lanes = '0;
        out_count = '0;
        if (out_valid) begin
            out_count = count_q[rb_q];
            for (int unsigned k = 0; k < LANES; k++) begin
                if (CNT_W'(k) < count_q[rb_q]) begin
                    out_lanes[k*ADDER_WIDTH +: ADDER_WIDTH] = data_q[rb_q][k];
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_lane_gather.sv
// Bench for adder_tree_lane_gather: directed scenarios plus a long random run,
// all checked against a queue-based model of packed vectors.
module tb_adder_tree_lane_gather;

    localparam int unsigned W     = 64;
    localparam int unsigned LANES = 8;
    localparam int unsigned CW    = 4;

    typedef struct {
        logic [LANES*W-1:0] lanes;
        int                 cnt;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_lanes;
    logic [CW-1:0]        out_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: completed vectors waiting downstream, and the partial one.
    vec_t         exp_q[$];
    logic [W-1:0] part_q[$];

    // Per-cycle observations for scenario-level checks.
    logic               obs_valid;
    logic               obs_ready;
    logic [LANES*W-1:0] obs_lanes;
    logic               last_acc;
    logic               last_drn;
    vec_t               got_q[$];
    int                 n_acc;

    adder_tree_lane_gather #(
        .ADDER_WIDTH(W),
        .LANES      (LANES),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lanes(out_lanes),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; checks outputs, then advances one rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                         input logic ordy);
        logic ready_idle, exp_ready, acc, drn;
        vec_t nv;
        in_valid  = 1'b0;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        ready_idle = in_ready;
        in_valid   = v;
        #1;
        exp_ready = rst_n && (exp_q.size() < 2);
        n_cmp++;
        if (in_ready !== exp_ready) begin
            n_err++;
            $display("FAIL in_ready: got %b exp %b (t=%0t)", in_ready, exp_ready, $time);
        end
        n_cmp++;
        if (in_ready !== ready_idle) begin
            n_err++;
            $display("FAIL in_ready_vs_in_valid: got %b with in_valid=1, %b with in_valid=0",
                     in_ready, ready_idle);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_count !== CW'(exp_q[0].cnt) ||
                out_lanes !== exp_q[0].lanes) begin
                n_err++;
                $display("FAIL out_vector: got v=%b cnt=%0d lanes=%h exp v=1 cnt=%0d lanes=%h",
                         out_valid, out_count, out_lanes, exp_q[0].cnt, exp_q[0].lanes);
            end
        end else begin
            n_cmp++;
            if (out_valid !== 1'b0 || out_count !== '0 || out_lanes !== '0) begin
                n_err++;
                $display("FAIL out_idle: got v=%b cnt=%0d lanes=%h exp all zero",
                         out_valid, out_count, out_lanes);
            end
        end
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_lanes = out_lanes;
        acc = v && exp_ready;
        drn = (exp_q.size() > 0) && ordy;
        @(posedge clk);
        last_acc = 1'b0;
        last_drn = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            if (drn) begin
                got_q.push_back(exp_q[0]);
                void'(exp_q.pop_front());
                last_drn = 1'b1;
            end
            if (acc) begin
                part_q.push_back(d);
                n_acc++;
                last_acc = 1'b1;
                if (part_q.size() == LANES || l) begin
                    nv.lanes = '0;
                    nv.cnt   = part_q.size();
                    foreach (part_q[k]) nv.lanes[k*W +: W] = part_q[k];
                    exp_q.push_back(nv);
                    part_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_full_vector();
        int pulses = 0;
        logic [W-1:0] sum = '0;
        got_q.delete();
        for (int i = 1; i <= LANES; i++) cycle(1'b1, W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            if (obs_valid) begin
                pulses++;
                for (int k = 0; k < LANES; k++) sum += obs_lanes[k*W +: W];
            end
        end
        n_cmp++;
        if (pulses != 1 || sum != 36) begin
            n_err++;
            $display("FAIL full_vector: got pulses=%0d sum=%0d exp 1 / 36", pulses, sum);
        end
    endtask

    task automatic test_short_vector();
        logic [LANES*W-1:0] exp_l = '0;
        got_q.delete();
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        cycle(1'b1, 64'd1, 1'b0, 1'b1);
        cycle(1'b1, 64'd2, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        exp_l[0 +: W]   = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_l[W +: W]   = 64'd1;
        exp_l[2*W +: W] = 64'd2;
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].lanes !== exp_l || got_q[0].cnt != 3) begin
            n_err++;
            $display("FAIL short_vector: got %0d vectors, first lanes=%h exp one 3-word vector",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].lanes : '0);
        end
    endtask

    task automatic test_backpressure();
        int w = 1;
        int budget;
        logic [LANES*W-1:0] held;
        got_q.delete();
        for (int c = 0; c < 24; c++) begin
            cycle(w <= 24, W'(w), 1'b0, 1'b0);
            if (last_acc) w++;
            if (c == 20) held = obs_lanes;
        end
        n_cmp++;
        if (w != 17) begin
            n_err++;
            $display("FAIL stall_accept_count: got %0d words accepted exp 16", w - 1);
        end
        n_cmp++;
        if (obs_lanes !== held || obs_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: lanes changed or in_ready=%b exp stable and 0", obs_ready);
        end
        budget = 200;
        while ((w <= 24 || exp_q.size() > 0 || part_q.size() > 0) && budget > 0) begin
            cycle(w <= 24, W'(w), 1'b0, 1'b1);
            if (last_acc) w++;
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL backpressure_timeout: got no drain in 200 cycles exp done");
        end
        for (int v = 0; v < 3; v++) begin
            logic [LANES*W-1:0] exp_l;
            for (int k = 0; k < LANES; k++) exp_l[k*W +: W] = W'(v * LANES + k + 1);
            n_cmp++;
            if (got_q.size() <= v || got_q[v].lanes !== exp_l) begin
                n_err++;
                $display("FAIL backpressure_order: vector %0d got %h exp %h", v,
                         (got_q.size() > v) ? got_q[v].lanes : '0, exp_l);
            end
        end
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        int pulses = 0;
        for (int c = 0; c < 64; c++) begin
            cycle(1'b1, W'(1000 + c), 1'b0, 1'b1);
            if (!obs_ready) drops++;
            if (obs_valid) pulses++;
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        if (obs_valid) pulses++;
        n_cmp++;
        if (drops != 0 || pulses != 8) begin
            n_err++;
            $display("FAIL back_to_back: got drops=%0d vectors=%0d exp 0 / 8", drops, pulses);
        end
    endtask

    task automatic test_reset_mid_vector();
        logic [LANES*W-1:0] exp_l;
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(50 + i), 1'b0, 1'b0);
        do_reset();
        got_q.delete();
        for (int i = 0; i < LANES; i++) cycle(1'b1, W'(100 + i), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < LANES; k++) exp_l[k*W +: W] = W'(100 + k);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].lanes !== exp_l || got_q[0].cnt != LANES) begin
            n_err++;
            $display("FAIL reset_mid_vector: got %0d vectors exp one 100..107", got_q.size());
        end
    endtask

    task automatic test_random();
        int start = n_acc;
        int budget = 60000;
        int ordy_bias;
        while (n_acc - start < 10000 && budget > 0) begin
            if (budget % 500 == 0) ordy_bias = $urandom_range(1, 4);
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) < ordy_bias);
            budget--;
        end
        cycle(1'b1, 64'd7, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (budget == 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_progress: got %0d words, %0d pending exp 10000 / 0",
                     n_acc - start, exp_q.size());
        end
    endtask

    initial begin
        n_acc = 0;
        test_reset();
        test_full_vector();
        test_short_vector();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_vector();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
